// File: rtl/vmem_fill_ctrl_pkg.sv
// Shared register map, CTRL bit positions and FSM types for the vmem rectangle-fill engine.
package vmem_fill_ctrl_pkg;

    localparam int VFC_WIDTH  = 240;
    localparam int VFC_HEIGHT = 240;

    localparam logic [4:0] VFC_REG_CTRL   = 5'h00;
    localparam logic [4:0] VFC_REG_P0     = 5'h04;
    localparam logic [4:0] VFC_REG_P1     = 5'h08;
    localparam logic [4:0] VFC_REG_COLOR  = 5'h0C;
    localparam logic [4:0] VFC_REG_STATUS = 5'h10;

    localparam int VFC_CTRL_START    = 0;
    localparam int VFC_CTRL_ABORT    = 1;
    localparam int VFC_CTRL_CLR_DONE = 2;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } vfc_state_t;

    function automatic logic [7:0] vfc_clamp(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vmem_fill_walker.sv
// Raster counter for the fill engine: walks {cy,cx} across the latched rectangle.
module vmem_fill_walker
    import vmem_fill_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       advance_i,
    input  logic       stall_i,
    input  logic [7:0] xs_i,
    input  logic [7:0] xe_i,
    input  logic [7:0] ys_i,
    input  logic [7:0] ye_i,
    output logic [7:0] cx_o,
    output logic [7:0] cy_o,
    output logic       last_o
);

    logic [7:0] cx_q;
    logic [7:0] cy_q;
    logic [7:0] xs_q;
    logic [7:0] xe_q;
    logic [7:0] ye_q;
    logic       step;

    // A stalled cycle holds the position so no pixel is skipped.
    assign step = advance_i & ~stall_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cx_q <= '0;
            cy_q <= '0;
            xs_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else if (load_i) begin
            cx_q <= xs_i;
            cy_q <= ys_i;
            xs_q <= xs_i;
            xe_q <= xe_i;
            ye_q <= ye_i;
        end else if (step) begin
            if (cx_q == xe_q) begin
                cx_q <= xs_q;
                cy_q <= cy_q + 8'd1;
            end else begin
                cx_q <= cx_q + 8'd1;
            end
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == xe_q) && (cy_q == ye_q);

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine sharing the vmem write port with the CPU; CPU stores always win.
module vmem_fill_ctrl
    import vmem_fill_ctrl_pkg::*;
#(
    parameter int WIDTH  = VFC_WIDTH,
    parameter int HEIGHT = VFC_HEIGHT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_we_i,
    input  logic [4:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_waddr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_waddr_o,
    output logic [7:0]  vmem_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [7:0] XMAX = 8'(WIDTH - 1);
    localparam logic [7:0] YMAX = 8'(HEIGHT - 1);

    vfc_state_t  state_q;
    vfc_state_t  state_d;

    logic [15:0] p0_q;
    logic [15:0] p1_q;
    logic [7:0]  color_q;
    logic [7:0]  fill_color_q;
    logic        done_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    logic        ctrl_wr;
    logic        cmd_start;
    logic        cmd_abort;
    logic        cmd_clr;
    logic [7:0]  xs_c;
    logic [7:0]  xe_c;
    logic [7:0]  ys_c;
    logic [7:0]  ye_c;
    logic        empty;

    logic        busy;
    logic        advance;
    logic        load;
    logic        eng_we;
    logic        done_set;

    logic [7:0]  cx;
    logic [7:0]  cy;
    logic        last;

    logic        unused_ok;

    assign unused_ok = ^cfg_wdata_i[31:16];

    assign ctrl_wr   = cfg_we_i && (cfg_addr_i == VFC_REG_CTRL);
    assign cmd_start = ctrl_wr & cfg_wdata_i[VFC_CTRL_START];
    assign cmd_abort = ctrl_wr & cfg_wdata_i[VFC_CTRL_ABORT];
    assign cmd_clr   = ctrl_wr & cfg_wdata_i[VFC_CTRL_CLR_DONE];

    assign xs_c  = vfc_clamp(p0_q[7:0], XMAX);
    assign ys_c  = vfc_clamp(p0_q[15:8], YMAX);
    assign xe_c  = vfc_clamp(p1_q[7:0], XMAX);
    assign ye_c  = vfc_clamp(p1_q[15:8], YMAX);
    assign empty = (xe_c < xs_c) || (ye_c < ys_c);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cmd_abort || (eng_we && last)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ABORT suppresses the engine write in the very cycle it is presented.
    always_comb begin
        busy     = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        eng_we   = 1'b0;
        done_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                load     = cmd_start & ~cmd_abort & ~empty;
                done_set = cmd_start & ~cmd_abort & empty;
            end
            ST_RUN: begin
                busy     = 1'b1;
                advance  = ~cmd_abort;
                eng_we   = ~cmd_abort & ~cpu_we_i;
                done_set = cmd_abort | (eng_we & last);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p0_q    <= '0;
            p1_q    <= '0;
            color_q <= '0;
        end else if (cfg_we_i) begin
            if (cfg_addr_i == VFC_REG_P0)    p0_q    <= cfg_wdata_i[15:0];
            if (cfg_addr_i == VFC_REG_P1)    p1_q    <= cfg_wdata_i[15:0];
            if (cfg_addr_i == VFC_REG_COLOR) color_q <= cfg_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_color_q <= '0;
        end else if (load) begin
            fill_color_q <= color_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
        end else if (done_set) begin
            done_q <= 1'b1;
        end else if (cmd_clr) begin
            done_q <= 1'b0;
        end
    end

    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            cfg_addr_i == VFC_REG_P0:     rdata_d = {16'h0, p0_q};
            cfg_addr_i == VFC_REG_P1:     rdata_d = {16'h0, p1_q};
            cfg_addr_i == VFC_REG_COLOR:  rdata_d = {24'h0, color_q};
            cfg_addr_i == VFC_REG_STATUS: rdata_d = {30'h0, done_q, busy};
            default:                      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    vmem_fill_walker u_walker (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load),
        .advance_i (advance),
        .stall_i   (cpu_we_i),
        .xs_i      (xs_c),
        .xe_i      (xe_c),
        .ys_i      (ys_c),
        .ye_i      (ye_c),
        .cx_o      (cx),
        .cy_o      (cy),
        .last_o    (last)
    );

    assign vmem_we_o    = cpu_we_i | eng_we;
    assign vmem_waddr_o = cpu_we_i ? cpu_waddr_i : {cy, cx};
    assign vmem_wdata_o = cpu_we_i ? cpu_wdata_i : fill_color_q;

    assign cfg_rdata_o = rdata_q;
    assign busy_o      = busy;
    assign done_o      = done_q;

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Randomized bench for vmem_fill_ctrl against a pixel-queue reference model.
module tb_vmem_fill_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cpu_we;
    logic [15:0] cpu_waddr;
    logic [7:0]  cpu_wdata;
    logic        vmem_we;
    logic [15:0] vmem_waddr;
    logic [7:0]  vmem_wdata;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] expq[$];

    vmem_fill_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata),
        .cpu_we_i     (cpu_we),
        .cpu_waddr_i  (cpu_waddr),
        .cpu_wdata_i  (cpu_wdata),
        .vmem_we_o    (vmem_we),
        .vmem_waddr_o (vmem_waddr),
        .vmem_wdata_o (vmem_wdata),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic we, input logic [15:0] a, input logic [7:0] d);
        return {7'h0, we, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
        cfg_addr = a;
        tick();
        d = cfg_rdata;
    endtask

    // Expected engine pixels: clamp to the screen, then raster rows top to bottom.
    task automatic model_fill(input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] x1, input logic [7:0] y1);
        int xs, xe, ys, ye;
        xs = (x0 > 239) ? 239 : int'(x0);
        xe = (x1 > 239) ? 239 : int'(x1);
        ys = (y0 > 239) ? 239 : int'(y0);
        ye = (y1 > 239) ? 239 : int'(y1);
        expq.delete();
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++)
                expq.push_back({y[7:0], x[7:0]});
    endtask

    task automatic run_fill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1,
                            input logic [7:0] col, input int rate,
                            input int cpu_at, input int restart_at,
                            input int abort_at, input logic [31:0] abort_d);
        int eng;
        int cyc;
        logic [31:0] exp;
        logic [31:0] rd;
        cfg_write(5'h00, 32'h4);
        chk("clr_done", {31'h0, done}, 32'h0);
        cfg_write(5'h04, {16'h0, y0, x0});
        cfg_write(5'h08, {16'h0, y1, x1});
        cfg_write(5'h0C, {24'h0, col});
        model_fill(x0, y0, x1, y1);
        cfg_we = 1'b1;
        cfg_addr = 5'h00;
        cfg_wdata = 32'h1;
        cpu_we = 1'b0;
        @(negedge clk);
        chk("start_cyc_we", {31'h0, vmem_we}, 32'h0);
        tick();
        cfg_we = 1'b0;
        eng = 0;
        cyc = 0;
        while (expq.size() > 0 && cyc < 20000) begin
            cpu_we = 1'b0;
            cfg_we = 1'b0;
            if (abort_at >= 0 && eng == abort_at) begin
                cfg_we = 1'b1;
                cfg_addr = 5'h00;
                cfg_wdata = abort_d;
                @(negedge clk);
                chk("abort_cyc_we", {31'h0, vmem_we}, 32'h0);
                tick();
                cfg_we = 1'b0;
                expq.delete();
                break;
            end
            if (cyc == cpu_at) begin
                cpu_we = 1'b1;
                cpu_waddr = 16'h1234;
                cpu_wdata = 8'h5A;
            end else if ($urandom_range(99) < rate) begin
                cpu_we = 1'b1;
                cpu_waddr = 16'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (eng == restart_at) begin
                cfg_we = 1'b1;
                cfg_addr = 5'h00;
                cfg_wdata = 32'h1;
            end
            if (cpu_we) begin
                exp = pk(1'b1, cpu_waddr, cpu_wdata);
            end else begin
                exp = pk(1'b1, expq.pop_front(), col);
                eng++;
            end
            @(negedge clk);
            chk("vmem_port", pk(vmem_we, vmem_waddr, vmem_wdata), exp);
            tick();
            cyc++;
        end
        cpu_we = 1'b0;
        cfg_we = 1'b0;
        chk("pending_pixels", expq.size(), 0);
        @(negedge clk);
        chk("end_busy", {31'h0, busy}, 32'h0);
        chk("end_done", {31'h0, done}, 32'h1);
        chk("idle_we", {31'h0, vmem_we}, 32'h0);
        cfg_read(5'h10, rd);
        chk("end_status", rd, 32'h2);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0] x0, y0, x1, y1;
        clk = 1'b0;
        rst_ni = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        cpu_we = 1'b0;
        cpu_waddr = '0;
        cpu_wdata = '0;
        #3;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_we", {31'h0, vmem_we}, 32'h0);
        chk("rst_rdata", cfg_rdata, 32'h0);
        cpu_we = 1'b1;
        cpu_waddr = 16'hBEEF;
        cpu_wdata = 8'h77;
        #1;
        chk("rst_pass", pk(vmem_we, vmem_waddr, vmem_wdata), pk(1'b1, 16'hBEEF, 8'h77));
        cpu_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cfg_read(5'h04, rd); chk("rst_p0", rd, 32'h0);
        cfg_read(5'h08, rd); chk("rst_p1", rd, 32'h0);
        cfg_read(5'h0C, rd); chk("rst_color", rd, 32'h0);
        cfg_read(5'h10, rd); chk("rst_status", rd, 32'h0);

        cfg_write(5'h0C, 32'h0000_00C3);
        cfg_read(5'h0C, rd); chk("color_rb", rd, 32'hC3);
        cfg_write(5'h14, 32'hFFFF_FFFF);
        cfg_read(5'h14, rd); chk("hole_rd", rd, 32'h0);

        run_fill(8'd0, 8'd0, 8'd1, 8'd1, 8'hE0, 0, -1, -1, -1, 32'h0);
        run_fill(8'd10, 8'd20, 8'd12, 8'd20, 8'h3C, 0, 1, -1, -1, 32'h0);
        run_fill(8'hF0, 8'd0, 8'hFF, 8'd0, 8'h11, 0, -1, -1, -1, 32'h0);
        run_fill(8'hE0, 8'd0, 8'hFF, 8'd0, 8'h22, 0, -1, -1, -1, 32'h0);
        run_fill(8'd5, 8'd3, 8'd4, 8'd9, 8'h33, 0, -1, -1, -1, 32'h0);
        run_fill(8'd0, 8'd0, 8'hFF, 8'hFF, 8'h44, 0, -1, -1, 100, 32'h2);
        cfg_write(5'h00, 32'h4);
        cfg_read(5'h10, rd); chk("clr_status", rd, 32'h0);
        run_fill(8'd5, 8'd5, 8'd14, 8'd7, 8'h55, 20, -1, 7, -1, 32'h0);
        run_fill(8'd50, 8'd60, 8'd70, 8'd65, 8'h66, 0, -1, -1, 10, 32'h3);

        for (int i = 0; i < 25; i++) begin
            x0 = 8'($urandom_range(0, 255));
            y0 = 8'($urandom_range(0, 255));
            x1 = x0 + 8'($urandom_range(0, 10));
            y1 = y0 + 8'($urandom_range(0, 6));
            run_fill(x0, y0, x1, y1, 8'($urandom), 30, -1, -1, -1, 32'h0);
        end

        cfg_write(5'h04, 32'h0);
        cfg_write(5'h08, 32'hEFEF);
        cfg_write(5'h0C, 32'h99);
        cfg_write(5'h00, 32'h1);
        repeat (20) tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_we", {31'h0, vmem_we}, 32'h0);
        cpu_we = 1'b1;
        cpu_waddr = 16'hABCD;
        cpu_wdata = 8'h11;
        #1;
        chk("midrst_pass", pk(vmem_we, vmem_waddr, vmem_wdata), pk(1'b1, 16'hABCD, 8'h11));
        cpu_we = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        cfg_read(5'h04, rd); chk("midrst_p0", rd, 32'h0);
        cfg_read(5'h08, rd); chk("midrst_p1", rd, 32'h0);
        cfg_read(5'h0C, rd); chk("midrst_color", rd, 32'h0);
        cfg_read(5'h10, rd); chk("midrst_status", rd, 32'h0);
        run_fill(8'd100, 8'd100, 8'd103, 8'd102, 8'hAB, 25, -1, -1, -1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
